// File: rtl/tile_skew_feeder_if.sv
// Bundle for tile_skew_feeder: control (start/base_addr/busy/done), SRAM read port and skewed output stream.
interface tile_skew_feeder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TILE_SIZE  = 16
);
  logic                            start;
  logic [ADDR_WIDTH-1:0]           base_addr;
  logic [ADDR_WIDTH-1:0]           sram_addr;
  logic                            sram_re;
  logic [DATA_WIDTH-1:0]           sram_rdata;
  logic [TILE_SIZE*DATA_WIDTH-1:0] out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic                            busy;
  logic                            done;

  modport master (
    input  start, base_addr, sram_rdata, out_ready,
    output sram_addr, sram_re, out_data, out_valid, busy, done
  );

  modport slave (
    output start, base_addr, sram_rdata, out_ready,
    input  sram_addr, sram_re, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/tile_skew_feeder.sv
// Loads a TxT tile from SRAM, then streams 2T-1 skewed vectors; first out_valid T*T+1 cycles after start, held while out_ready=0.
// Define TILE_SKEW_FEEDER_TRANSPOSE_EN for column feed (B operand); timing is identical either way.
module tile_skew_feeder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TILE_SIZE  = 16
) (
  input  logic                clk,
  input  logic                rst,
  tile_skew_feeder_if.master  bus
);

  localparam int T  = TILE_SIZE;
  localparam int N  = T * T;
  localparam int IW = $clog2(N);
  localparam int KW = $clog2(2 * T);
  localparam int OW = T * DATA_WIDTH;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [KW-1:0] LAST_K   = KW'(2 * T - 2);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, STREAM, DONE} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           rd_cnt_q, rd_cnt_d;
  logic [IW-1:0]           cap_idx_q, cap_idx_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [KW-1:0]           k_q, k_d;
  logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
  logic                    sram_re_q, sram_re_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [OW-1:0]           out_data_q, out_data_d;
  logic [OW-1:0]           skew_dat;
  logic [DATA_WIDTH-1:0]   tile_q [N];
  int                      d;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    k_d         = k_q;
    sram_addr_d = '0;
    rd_pend_d   = sram_re_q;
    cap_idx_d   = rd_pend_q ? cap_idx_q + 1'b1 : cap_idx_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = LOAD;
          rd_cnt_d    = '0;
          cap_idx_d   = '0;
          sram_addr_d = bus.base_addr;
        end
      end
      LOAD: begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          sram_addr_d = sram_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = STREAM;
        k_d     = '0;
      end
      STREAM: begin
        if (out_valid_q && bus.out_ready) begin
          if (k_q == LAST_K) begin
            state_d = DONE;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered images of the next state.
    sram_re_d   = (state_d == LOAD);
    out_valid_d = (state_d == STREAM);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // Step k=0 reads only element 0, so the last element landing on the DRAIN edge is never needed yet.
  always_comb begin
    skew_dat = '0;
    d        = 0;
    for (int r = 0; r < T; r++) begin
      d = int'(k_d) - r;
      if (d >= 0 && d < T) begin
`ifdef TILE_SKEW_FEEDER_TRANSPOSE_EN
        skew_dat[r*DATA_WIDTH +: DATA_WIDTH] = tile_q[IW'(d * T + r)];
`else
        skew_dat[r*DATA_WIDTH +: DATA_WIDTH] = tile_q[IW'(r * T + d)];
`endif
      end
    end
    out_data_d = out_valid_d ? skew_dat : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      cap_idx_q   <= '0;
      rd_pend_q   <= 1'b0;
      k_q         <= '0;
      sram_addr_q <= '0;
      sram_re_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      cap_idx_q   <= cap_idx_d;
      rd_pend_q   <= rd_pend_d;
      k_q         <= k_d;
      sram_addr_q <= sram_addr_d;
      sram_re_q   <= sram_re_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_data_q  <= out_data_d;
    end
  end

  // Tile storage deliberately survives reset.
  always_ff @(posedge clk) begin
    if (rd_pend_q) begin
      tile_q[cap_idx_q] <= bus.sram_rdata;
    end
  end

  assign bus.sram_addr = sram_addr_q;
  assign bus.sram_re   = sram_re_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_tile_skew_feeder.sv
// Bench for tile_skew_feeder (T=4): per-cycle compare against a phase-level reference model plus literal tile checks.
module tb_tile_skew_feeder;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int T  = 4;
  localparam int N  = T * T;
  localparam int NK = 2 * T - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_skew_feeder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TILE_SIZE(T)) bus ();

  tile_skew_feeder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TILE_SIZE(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] tile_base = '0;
  logic [DW-1:0] salt      = '0;

  // Reference model: 0 idle, 1 load, 2 drain, 3 stream, 4 done
  int            m_phase = 0;
  int            m_cnt   = 0;
  int            m_k     = 0;
  logic [AW-1:0] m_base  = '0;

  logic [T*DW-1:0] acc_q[$];
  logic [AW-1:0]   addr_log[$];
  int              done_cnt = 0;
  bit              mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_lane(input int k, input int r);
    int dd;
    int idx;
    dd = k - r;
    if (dd < 0 || dd >= T) return '0;
`ifdef TILE_SKEW_FEEDER_TRANSPOSE_EN
    idx = dd * T + r;
`else
    idx = r * T + dd;
`endif
    return DW'(idx + 1) ^ salt;
  endfunction

  function automatic logic [T*DW-1:0] exp_vec(input int k);
    logic [T*DW-1:0] v;
    v = '0;
    for (int r = 0; r < T; r++) v[r*DW +: DW] = exp_lane(k, r);
    return v;
  endfunction

  function automatic logic [T*DW-1:0] lanes(input int a, input int b, input int c, input int e);
    return {DW'(e), DW'(c), DW'(b), DW'(a)};
  endfunction

  // SRAM: one-cycle read latency, content (addr - tile_base + 1) ^ salt
  always @(posedge clk) begin
    if (bus.sram_re) bus.sram_rdata <= DW'(bus.sram_addr - tile_base + 1) ^ salt;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy",      64'(bus.busy),      64'(m_phase != 0));
      check("done",      64'(bus.done),      64'(m_phase == 4));
      check("sram_re",   64'(bus.sram_re),   64'(m_phase == 1));
      if (m_phase == 1) check("sram_addr", 64'(bus.sram_addr), 64'(AW'(m_base + AW'(m_cnt))));
      check("out_valid", 64'(bus.out_valid), 64'(m_phase == 3));
      check("out_data",  64'(bus.out_data),  64'((m_phase == 3) ? exp_vec(m_k) : '0));
      if (bus.sram_re) addr_log.push_back(bus.sram_addr);
      if (bus.out_valid && bus.out_ready) acc_q.push_back(bus.out_data);
      if (bus.done) done_cnt++;
      if (rst) begin
        m_phase = 0;
        m_k     = 0;
      end else begin
        case (m_phase)
          0: if (bus.start) begin m_phase = 1; m_cnt = 0; m_base = bus.base_addr; end
          1: if (m_cnt == N - 1) m_phase = 2; else m_cnt++;
          2: begin m_phase = 3; m_k = 0; end
          3: if (bus.out_ready) begin if (m_k == NK - 1) m_phase = 4; else m_k++; end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tile(input logic [AW-1:0] b, input logic [DW-1:0] s,
                          input bit rnd, input bit repulse, input int stall_n);
    int d0;
    int n;
    int st;
    d0 = done_cnt;
    st = stall_n;
    tile_base = b;
    salt = s;
    acc_q.delete();
    addr_log.delete();
    bus.base_addr = b;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.base_addr = AW'($urandom);
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      if (repulse && n == 5) begin
        bus.start = 1'b1;
        bus.base_addr = b + 16'h0040;
      end else begin
        bus.start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (st > 0 && m_phase == 3 && m_k == 2) begin
        bus.out_ready = 1'b0;
`ifdef TILE_SKEW_FEEDER_TRANSPOSE_EN
        check("stall_hold", 64'(bus.out_data), 64'(lanes(9, 6, 3, 0)));
`else
        check("stall_hold", 64'(bus.out_data), 64'(lanes(3, 6, 9, 0)));
`endif
        st--;
      end else begin
        bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      cyc();
      n++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    check("done_timeout", 64'(n < 400), 64'(1));
    check("accepted",     64'(acc_q.size()), 64'(NK));
    check("done_once",    64'(done_cnt - d0), 64'(1));
    check("read_count",   64'(addr_log.size()), 64'(N));
  endtask

  initial begin
    int n;
    int d0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_busy",      64'(bus.busy),      64'(0));
    check("rst_done",      64'(bus.done),      64'(0));
    check("rst_sram_re",   64'(bus.sram_re),   64'(0));
    check("rst_sram_addr", 64'(bus.sram_addr), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data",  64'(bus.out_data),  64'(0));
    mon_en = 1'b1;
    rst = 1'b0;
    cyc();

    run_tile(16'h0100, '0, 1'b0, 1'b0, 0);
    check("addr_first", 64'(addr_log[0]),  64'(16'h0100));
    check("addr_last",  64'(addr_log[15]), 64'(16'h010F));
    check("k0_vec", 64'(acc_q[0]), 64'(lanes(1, 0, 0, 0)));
`ifdef TILE_SKEW_FEEDER_TRANSPOSE_EN
    check("k3_vec", 64'(acc_q[3]), 64'(lanes(13, 10, 7, 4)));
`else
    check("k3_vec", 64'(acc_q[3]), 64'(lanes(4, 7, 10, 13)));
`endif
    check("k6_vec", 64'(acc_q[6]), 64'(lanes(0, 0, 0, 16)));

    // back-to-back start right after DONE, with a 3-cycle stall at k=2
    run_tile(16'h0200, '0, 1'b0, 1'b0, 3);

    run_tile(16'hFFFC, '0, 1'b0, 1'b0, 0);
    check("wrap_0",  64'(addr_log[0]),  64'(16'hFFFC));
    check("wrap_3",  64'(addr_log[3]),  64'(16'hFFFF));
    check("wrap_4",  64'(addr_log[4]),  64'(16'h0000));
    check("wrap_15", 64'(addr_log[15]), 64'(16'h000B));

    run_tile(16'h0300, '0, 1'b0, 1'b1, 0);
    check("repulse_first", 64'(addr_log[0]),  64'(16'h0300));
    check("repulse_last",  64'(addr_log[15]), 64'(16'h030F));

    // abort with reset mid-stream at k=4
    tile_base = 16'h0400;
    salt = '0;
    bus.base_addr = 16'h0400;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    n = 0;
    while (!(m_phase == 3 && m_k == 4) && n < 200) begin
      cyc();
      n++;
    end
    check("abort_reach_k4", 64'(n < 200), 64'(1));
    d0 = done_cnt;
    rst = 1'b1;
    cyc();
    check("abort_valid", 64'(bus.out_valid), 64'(0));
    check("abort_busy",  64'(bus.busy),      64'(0));
    rst = 1'b0;
    repeat (5) cyc();
    check("abort_no_done", 64'(done_cnt - d0), 64'(0));
    run_tile(16'h0500, '0, 1'b0, 1'b0, 0);
    check("post_abort_k0", 64'(acc_q[0]), 64'(lanes(1, 0, 0, 0)));

    for (int i = 0; i < 8; i++) begin
      run_tile(AW'($urandom), DW'($urandom), 1'b1, 1'b0, 0);
    end

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_skew_feeder.md
TILE_SKEW_FEEDER -- requirements
Module: tile_skew_feeder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, the SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, the element width (BF16).
REQ-003 SHALL have parameter TILE_SIZE, default 16, the tile dimension T (tile is T x T, T>=2).
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  the reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  launches one tile transfer; sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  the SRAM address of tile element (0,0), sampled with start.
REQ-008 SHALL have port sram_addr  output  ADDR_WIDTH  the SRAM read address.
REQ-009 SHALL have port sram_re  output  1  the SRAM read enable.
REQ-010 SHALL have port sram_rdata  input  DATA_WIDTH  the read data, valid the cycle after sram_re.
REQ-011 SHALL have port out_data  output  T*DATA_WIDTH  the skewed vector, with lane r at bits [r*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port out_valid  output  1  qualifies out_data.
REQ-013 SHALL have port out_ready  input  1  the systolic-array side accept.
REQ-014 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-015 SHALL have port done  output  1  a one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, DRAIN, STREAM, DONE.
REQ-017 SHALL move IDLE->LOAD when start=1, latching base_addr; start in any other state SHALL be ignored.
REQ-018 SHALL, in LOAD, assert sram_re for exactly T*T consecutive cycles with sram_addr = base_addr+i, i=0..T*T-1.
REQ-019 SHALL compute addresses modulo 2^ADDR_WIDTH, so they wrap past all-ones to zero.
REQ-020 SHALL capture sram_rdata one cycle after each read into internal buffer buf[i/T][i%T] (row-major).
REQ-021 SHALL move LOAD->DRAIN after the last read; DRAIN lasts one cycle, captures the last element, then moves to STREAM.
REQ-022 SHALL hold sram_re=0 outside LOAD; out_valid SHALL first rise T*T+1 cycles after the edge that samples start.
REQ-023 SHALL, in STREAM, hold out_valid=1 and present step k=0..2T-2; lane r = buf[r][k-r] when 0<=k-r<T, else zero.
REQ-024 SHALL advance k only on out_valid&&out_ready; while out_ready=0, out_data and k SHALL hold stable.
REQ-025 SHALL move STREAM->DONE on acceptance of step k=2T-2; DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-026 SHALL drive out_data=0 whenever out_valid=0.
REQ-027 SHALL accept a start in IDLE on the cycle immediately after DONE, with no dead cycle.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, force IDLE and k=0, and drive sram_addr, sram_re, out_data, out_valid, busy and done to 0.
REQ-029 SHALL abandon the transfer when rst is asserted in any state (including mid-LOAD or mid-STREAM), with no done pulse.
REQ-030 SHALL NOT clear buffer contents on reset.

Configuration
REQ-031 SHALL support macro TILE_SKEW_FEEDER_TRANSPOSE_EN; when defined, lane r = buf[k-r][r] (column feed for the B operand).
REQ-032 SHALL, when TILE_SKEW_FEEDER_TRANSPOSE_EN is undefined, use row feed per REQ-023; all timing SHALL be identical either way.

Verification (T=4, DATA_WIDTH=16, SRAM model mem[a]=(a-base)+1 over the tile, out_ready=1 unless stated)
REQ-033 SHALL cover: rst held 2 cycles -> all outputs 0, busy=0, state IDLE.
REQ-034 SHALL cover: base_addr=0x0100, start pulse -> sram_addr 0x0100..0x010F with sram_re=1 for 16 cycles; 7 vectors out; k=0 lanes {1,0,0,0}; k=3 lanes {4,7,10,13}; k=6 lanes {0,0,0,16}; done pulses once.
REQ-035 SHALL cover: out_ready=0 for 3 cycles at k=2 -> out_data holds {3,6,9,0}; still exactly 7 accepted vectors.
REQ-036 SHALL cover: base_addr=0xFFFC -> sram_addr sequence 0xFFFC..0xFFFF, then 0x0000..0x000B.
REQ-037 SHALL cover: start re-pulsed mid-LOAD -> ignored, address sequence unchanged; rst at k=4 -> next cycle out_valid=0, busy=0, no done; a fresh start then completes normally.
REQ-038 SHALL cover, with TILE_SKEW_FEEDER_TRANSPOSE_EN defined: k=3 lanes {13,10,7,4}; k=0 lanes {1,0,0,0}.
